// File: rtl/instr_fetch_queue.sv
// Fetch stage for the IF/ID boundary.
// Owns the fetch PC and issues requests to a synchronous instruction memory
// (data returns one cycle after the request). Returned {pc, instr} pairs are
// buffered in a small FIFO that decode drains through id_valid_o/id_ready_i.
// A redirect from EX flushes the FIFO, drops the response in flight and
// restarts fetch at the target.
module instr_fetch_queue #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             imem_req_o,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_data_i,
   input  logic             redirect_i,
   input  logic [31:0]      redirect_pc_i,
   output logic             id_valid_o,
   output logic [31:0]      id_instr_o,
   output logic [31:0]      id_pc_o,
   input  logic             id_ready_i,
   output logic [CNT_W-1:0] count_o
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

   // Pointer advance; DEPTH is a power of two so the natural wrap is correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
   endfunction

   logic [31:0]      fetch_pc_r;
   logic             inflight_r;
   logic [31:0]      inflight_pc_r;
   logic [CNT_W-1:0] count_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [31:0]      pc_mem_r    [DEPTH];
   logic [31:0]      instr_mem_r [DEPTH];

   logic             valid_s;
   logic             pop_s;
   logic             push_s;
   logic             issue_s;
   logic [CNT_W:0]   credit_s;
   logic [31:0]      redirect_tgt_s;

   assign valid_s        = (count_r != {CNT_W{1'b0}});
   assign pop_s          = valid_s & id_ready_i & ~redirect_i;
   // A response arriving in a redirect cycle belongs to the wrong path.
   assign push_s         = inflight_r & ~redirect_i;
   assign redirect_tgt_s = redirect_pc_i & 32'hFFFF_FFFC;

   // Credit: a new request is allowed only if its response is guaranteed a slot,
   // counting the entry being popped this cycle (keeps one instr/cycle at DEPTH=2).
   always_comb begin
      credit_s = {1'b0, count_r}
               + {{CNT_W{1'b0}}, inflight_r}
               - {{CNT_W{1'b0}}, pop_s};
      if (credit_s < DEPTH_W) begin
         issue_s = ~rst_i & ~redirect_i;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Fetch PC and the single outstanding memory request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_r    <= PC_RESET;
         inflight_r    <= 1'b0;
         inflight_pc_r <= 32'h0000_0000;
      end else if (redirect_i) begin
         fetch_pc_r    <= redirect_tgt_s;
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end else if (issue_s) begin
         fetch_pc_r    <= fetch_pc_r + 32'd4;
         inflight_r    <= 1'b1;
         inflight_pc_r <= fetch_pc_r;
      end else begin
         fetch_pc_r    <= fetch_pc_r;
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
      end
   end

   // FIFO occupancy and pointers; redirect empties the queue.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_r  <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
      end else if (redirect_i) begin
         count_r  <= {CNT_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
         rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
         wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      end
   end

   // FIFO storage: write the returned {pc, instr} pair at the tail.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]    <= 32'h0000_0000;
            instr_mem_r[i] <= 32'h0000_0000;
         end
      end else if (push_s) begin
         pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
         instr_mem_r[wr_ptr_r] <= imem_data_i;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]    <= pc_mem_r[i];
            instr_mem_r[i] <= instr_mem_r[i];
         end
      end
   end

   // Head entry presented to decode, forced to zero while the queue is empty.
   always_comb begin
      if (valid_s) begin
         id_pc_o    = pc_mem_r[rd_ptr_r];
         id_instr_o = instr_mem_r[rd_ptr_r];
      end else begin
         id_pc_o    = 32'h0000_0000;
         id_instr_o = 32'h0000_0000;
      end
   end

   assign imem_req_o  = issue_s;
   assign imem_addr_o = fetch_pc_r;
   assign id_valid_o  = valid_s;
   assign count_o     = count_r;

endmodule
